// File: rtl/router_controller_mp.sv
// router_controller_mp
//   Control plane of a multi-port router node. Three independent FSMs:
//     - read FSM : held read_req/read_gnt handshake toward the memory arbiter,
//                  one-cycle done pulse on grant, no retrigger while start_req
//                  stays high.
//     - forward  : round-robin arbitration over NUM_PORTS input FIFOs
//                  (port 0 = local inject, others = network), one flit every
//                  3 cycles (IDLE -> READ -> ROUTE), TTL deliver/forward/drop.
//     - write FSM: held write_req/write_gnt handshake, then one read strobe
//                  to the local output port.
//   A header generator stamps {TTL_INIT, seq, SRC_ID} on every ready_encap.
// Ports
//   clk, rst                        : clock, async active-high reset
//   start_req/start_src_addr/done   : read job from the total controller
//   read_req/read_gnt/src_addr      : arbiter read handshake
//   start_dst_addr/ready_encap      : header request from local encapsulator
//   hdr_dst_addr/hdr_out            : header to the encapsulator
//   in_empty/in_rd/in_data          : input FIFO side (port p at p*DATA_WIDTH)
//   out_full_local/out_full_fwd     : output FIFO back-pressure
//   out_data/out_we_local/out_we_fwd: routed flit and write strobes
//   drop_cnt                        : saturating count of TTL-expired flits
//   valid_rx/rx_dst_addr            : received packet waiting locally
//   write_req/write_gnt/dst_addr    : arbiter write handshake
//   rd_output_local                 : read strobe to the local output port
module router_controller_mp #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 10,
  parameter int NUM_PORTS     = 4,
  parameter int NUMBER_PACKET = 19,
  parameter int TTL_W         = 2,
  parameter int TTL_INIT      = 2,
  parameter int SEQ_W         = 5,
  parameter int SRC_W         = 2,
  parameter int SRC_ID        = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_req,
  input  logic [ADDR_WIDTH-1:0]           start_src_addr,
  input  logic [ADDR_WIDTH-1:0]           start_dst_addr,
  output logic                            done,
  output logic                            read_req,
  input  logic                            read_gnt,
  output logic [ADDR_WIDTH-1:0]           src_addr,
  input  logic                            ready_encap,
  output logic [ADDR_WIDTH-1:0]           hdr_dst_addr,
  output logic [TTL_W+SEQ_W+SRC_W-1:0]    hdr_out,
  input  logic [NUM_PORTS-1:0]            in_empty,
  output logic [NUM_PORTS-1:0]            in_rd,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic                            out_full_local,
  input  logic                            out_full_fwd,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_we_local,
  output logic                            out_we_fwd,
  output logic [15:0]                     drop_cnt,
  input  logic                            valid_rx,
  input  logic [ADDR_WIDTH-1:0]           rx_dst_addr,
  output logic                            write_req,
  input  logic                            write_gnt,
  output logic [ADDR_WIDTH-1:0]           dst_addr,
  output logic                            rd_output_local
);

  localparam int HW      = TTL_W + SEQ_W + SRC_W;
  localparam int TTL_MSB = HW - 1;
  localparam int PW      = $clog2(NUM_PORTS);
  localparam logic [PW:0]   NP_W = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT}   rstate_t;
  typedef enum logic [1:0] {F_IDLE, F_READ, F_ROUTE} fstate_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RD}     wstate_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  we_local;
    logic                  we_fwd;
    logic                  drop;
  } route_t;

  rstate_t rstate;
  fstate_t fstate;
  wstate_t wstate;

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate   <= R_IDLE;
      read_req <= 1'b0;
      done     <= 1'b0;
      src_addr <= '0;
    end else begin
      done <= 1'b0;
      case (rstate)
        R_IDLE: if (start_req) begin
          src_addr <= start_src_addr;
          read_req <= 1'b1;
          rstate   <= R_REQ;
        end
        R_REQ: begin
          if (!start_req) begin
            // job withdrawn before grant: release the arbiter
            read_req <= 1'b0;
            rstate   <= R_IDLE;
          end else if (read_gnt) begin
            read_req <= 1'b0;
            done     <= 1'b1;
            rstate   <= R_WAIT;
          end
        end
        R_WAIT: if (!start_req) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- header generator ----------------
  logic [SEQ_W-1:0] seq, seq_next;
  assign seq_next = (seq == SEQ_W'(NUMBER_PACKET) || seq == '0) ? SEQ_W'(1)
                                                               : seq + SEQ_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq          <= '0;
      hdr_out      <= '0;
      hdr_dst_addr <= '0;
    end else if (ready_encap) begin
      seq          <= seq_next;
      hdr_out      <= {TTL_W'(TTL_INIT), seq_next, SRC_W'(SRC_ID)};
      hdr_dst_addr <= start_dst_addr;
    end
  end

  // ---------------- forward path ----------------
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data;
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    assign port_data[gp] = in_data[gp*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [PW-1:0] rr_ptr, sel, pick;
  logic          found;
  logic [PW:0]   idx;

  // first non-empty port at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= NP_W) idx = idx - NP_W;
      if (!found && !in_empty[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  logic [DATA_WIDTH-1:0] flit;
  logic [TTL_W-1:0]      ttl;
  route_t                rt;

  assign flit = port_data[sel];
  assign ttl  = flit[TTL_MSB -: TTL_W];

  // local inject is always forwarded untouched; network flits age by one hop
  always_comb begin
    rt = '{data: flit, we_local: 1'b0, we_fwd: 1'b0, drop: 1'b0};
    if (sel == '0) begin
      rt.we_fwd = 1'b1;
    end else if (ttl > TTL_W'(1)) begin
      rt.data[TTL_MSB -: TTL_W] = ttl - TTL_W'(1);
      rt.we_local = 1'b1;
      rt.we_fwd   = 1'b1;
    end else if (ttl == TTL_W'(1)) begin
      rt.data[TTL_MSB -: TTL_W] = '0;
      rt.we_local = 1'b1;
    end else begin
      rt.drop = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fstate       <= F_IDLE;
      rr_ptr       <= '0;
      sel          <= '0;
      in_rd        <= '0;
      out_data     <= '0;
      out_we_local <= 1'b0;
      out_we_fwd   <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      in_rd        <= '0;
      out_we_local <= 1'b0;
      out_we_fwd   <= 1'b0;
      case (fstate)
        F_IDLE: if (!out_full_local && !out_full_fwd && found) begin
          sel    <= pick;
          in_rd  <= NUM_PORTS'(1) << pick;
          rr_ptr <= (pick == LAST) ? '0 : pick + PW'(1);
          fstate <= F_READ;
        end
        // FIFO output becomes valid the cycle after the strobe
        F_READ: fstate <= F_ROUTE;
        F_ROUTE: begin
          if (rt.drop) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end else begin
            out_data     <= rt.data;
            out_we_local <= rt.we_local;
            out_we_fwd   <= rt.we_fwd;
          end
          fstate <= F_IDLE;
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate          <= W_IDLE;
      write_req       <= 1'b0;
      dst_addr        <= '0;
      rd_output_local <= 1'b0;
    end else begin
      rd_output_local <= 1'b0;
      case (wstate)
        W_IDLE: if (valid_rx) begin
          dst_addr  <= rx_dst_addr;
          write_req <= 1'b1;
          wstate    <= W_REQ;
        end
        W_REQ: if (write_gnt) begin
          write_req       <= 1'b0;
          rd_output_local <= 1'b1;
          wstate          <= W_RD;
        end
        W_RD: wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_controller_mp.sv
module tb_router_controller_mp;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int AW = 10;

  logic clk, rst;
  logic start_req, done, read_req, read_gnt;
  logic [AW-1:0] start_src_addr, start_dst_addr, src_addr, hdr_dst_addr;
  logic ready_encap;
  logic [8:0] hdr_out;
  logic [NP-1:0] in_empty, in_rd;
  logic [NP*DW-1:0] in_data;
  logic out_full_local, out_full_fwd, out_we_local, out_we_fwd;
  logic [DW-1:0] out_data;
  logic [15:0] drop_cnt;
  logic valid_rx, write_req, write_gnt, rd_output_local;
  logic [AW-1:0] rx_dst_addr, dst_addr;

  router_controller_mp dut (
    .clk(clk), .rst(rst), .start_req(start_req), .start_src_addr(start_src_addr),
    .start_dst_addr(start_dst_addr), .done(done), .read_req(read_req),
    .read_gnt(read_gnt), .src_addr(src_addr), .ready_encap(ready_encap),
    .hdr_dst_addr(hdr_dst_addr), .hdr_out(hdr_out), .in_empty(in_empty),
    .in_rd(in_rd), .in_data(in_data), .out_full_local(out_full_local),
    .out_full_fwd(out_full_fwd), .out_data(out_data), .out_we_local(out_we_local),
    .out_we_fwd(out_we_fwd), .drop_cnt(drop_cnt), .valid_rx(valid_rx),
    .rx_dst_addr(rx_dst_addr), .write_req(write_req), .write_gnt(write_gnt),
    .dst_addr(dst_addr), .rd_output_local(rd_output_local)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input FIFO model: data appears on in_data the cycle after the strobe
  logic [DW-1:0] fifo_mem [NP][32];
  int            wr_ptr [NP];
  int            rd_ptr [NP];
  logic [DW-1:0] in_data_r [NP];

  always @(posedge clk)
    for (int p = 0; p < NP; p++)
      if (in_rd[p] && rd_ptr[p] != wr_ptr[p]) begin
        in_data_r[p] <= fifo_mem[p][rd_ptr[p]];
        rd_ptr[p]    <= rd_ptr[p] + 1;
      end

  always_comb begin
    in_empty = '0;
    in_data  = '0;
    for (int p = 0; p < NP; p++) begin
      in_empty[p]          = (rd_ptr[p] == wr_ptr[p]);
      in_data[p*DW +: DW]  = in_data_r[p];
    end
  end

  // scoreboard queues
  typedef struct packed {
    logic [DW-1:0] data;
    logic          we_l;
    logic          we_f;
  } flit_exp_t;
  flit_exp_t       exp_flit [$];
  logic [NP-1:0]   exp_grant [$];
  logic [18:0]     exp_hdr [$];
  string           chk_name [$];
  logic [63:0]     chk_act [$];
  logic [63:0]     chk_exp [$];

  int n_checks = 0;
  int n_errors = 0;
  int rdreq_cyc = 0, done_cnt = 0, wrreq_cyc = 0, rdout_cnt = 0, strobe_cnt = 0;
  logic rdy_q = 1'b0;

  always @(posedge clk) rdy_q <= ready_encap;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor: the only process that compares and counts
  always @(negedge clk) begin
    flit_exp_t f;
    if (read_req)        rdreq_cyc++;
    if (done)            done_cnt++;
    if (write_req)       wrreq_cyc++;
    if (rd_output_local) rdout_cnt++;
    if (in_rd != '0) begin
      strobe_cnt++;
      if (exp_grant.size() == 0) cmp("grant_unexpected", 64'(in_rd), 64'd0);
      else                       cmp("grant", 64'(in_rd), 64'(exp_grant.pop_front()));
    end
    if (out_we_local || out_we_fwd) begin
      if (exp_flit.size() == 0) cmp("flit_unexpected", out_data, 64'd0);
      else begin
        f = exp_flit.pop_front();
        cmp("flit_data", out_data, f.data);
        cmp("flit_we", {62'd0, out_we_local, out_we_fwd}, {62'd0, f.we_l, f.we_f});
      end
    end
    if (rdy_q && !rst) begin
      if (exp_hdr.size() == 0) cmp("hdr_unexpected", 64'(hdr_out), 64'd0);
      else                     cmp("hdr", 64'({hdr_out, hdr_dst_addr}), 64'(exp_hdr.pop_front()));
    end
    while (chk_name.size() > 0)
      cmp(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
  end

  task automatic want(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_name.push_back(name);
    chk_act.push_back(act);
    chk_exp.push_back(exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_port(input int p, input logic [DW-1:0] d);
    fifo_mem[p][wr_ptr[p]] = d;
    wr_ptr[p]++;
  endtask

  task automatic exp_f(input logic [DW-1:0] d, input logic l, input logic f);
    exp_flit.push_back('{data: d, we_l: l, we_f: f});
  endtask

  task automatic check_idle(input string tag);
    want({tag, "_read_req"},  64'(read_req), 0);
    want({tag, "_done"},      64'(done), 0);
    want({tag, "_in_rd"},     64'(in_rd), 0);
    want({tag, "_out_we"},    64'({out_we_local, out_we_fwd}), 0);
    want({tag, "_write_req"}, 64'(write_req), 0);
    want({tag, "_rd_out"},    64'(rd_output_local), 0);
    want({tag, "_drop_cnt"},  64'(drop_cnt), 0);
    want({tag, "_hdr"},       64'(hdr_out), 0);
    want({tag, "_addrs"},     64'({src_addr, dst_addr}), 0);
    want({tag, "_out_data"},  out_data, 0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (exp_flit.size() + exp_grant.size() + exp_hdr.size()) != 0; i++)
      tick(1);
    want("drain", 64'(exp_flit.size() + exp_grant.size() + exp_hdr.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_idle("rst");
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int r0, d0, w0, o0, s0, got;
    rst = 1'b1;
    start_req = 0; start_src_addr = '0; start_dst_addr = '0; read_gnt = 0;
    ready_encap = 0; out_full_local = 0; out_full_fwd = 0;
    valid_rx = 0; rx_dst_addr = '0; write_gnt = 0;
    tick(3);
    check_idle("por");
    rst = 1'b0;

    // read handshake: grant seen on the 3rd edge after the request rises
    r0 = rdreq_cyc; d0 = done_cnt;
    start_req = 1; start_src_addr = 10'h155;
    tick(3);
    read_gnt = 1;
    tick(1);
    read_gnt = 0;
    tick(10);
    want("rd_req_cycles", 64'(rdreq_cyc - r0), 3);
    want("rd_done_pulses", 64'(done_cnt - d0), 1);
    want("rd_src_addr", 64'(src_addr), 64'h155);
    want("rd_no_retrigger", 64'(read_req), 0);
    start_req = 0;
    tick(2);
    // withdrawal before grant releases the request
    start_req = 1; start_src_addr = 10'h0F0;
    tick(1);
    want("rd_abort_req_hi", 64'(read_req), 1);
    start_req = 0;
    tick(1);
    want("rd_abort_req_lo", 64'(read_req), 0);
    start_req = 1;
    tick(1);
    want("rd_abort_reidle", 64'(read_req), 1);
    start_req = 0;
    tick(2);

    // headers: 11 back-to-back then 10 isolated pulses
    start_dst_addr = 10'h3C3;
    for (int k = 0; k < 21; k++) begin
      exp_hdr.push_back({2'd2, 5'((k % 19) + 1), 2'd0, 10'h3C3});
      ready_encap = 1;
      tick(1);
      if (k >= 10) begin
        ready_encap = 0;
        tick(1);
      end
    end
    ready_encap = 0;
    tick(2);
    wait_drain();

    // TTL decisions on port 2
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b0100); exp_grant.push_back(4'b0100);
    exp_f(64'h0123_4567_89AB_C0D5, 1, 1);
    exp_f(64'hFEDC_BA98_7654_3200, 1, 0);
    push_port(2, 64'h0123_4567_89AB_C155);
    push_port(2, 64'hFEDC_BA98_7654_3280);
    push_port(2, 64'h5555_0000_0000_0003);
    wait_drain();
    tick(6);
    want("drop_cnt", 64'(drop_cnt), 1);

    // round-robin from a fresh pointer
    do_reset();
    tick(1);
    exp_grant.push_back(4'b0001); exp_grant.push_back(4'b0010);
    exp_grant.push_back(4'b0100); exp_grant.push_back(4'b1000);
    exp_grant.push_back(4'b0001);
    exp_f(64'h1111_0000_0000_0155, 0, 1);
    exp_f(64'h2222_0000_0000_0080, 1, 1);
    exp_f(64'h3333_0000_0000_0000, 1, 0);
    exp_f(64'h4444_0000_0000_0100, 1, 1);
    exp_f(64'h1111_0000_0000_0000, 0, 1);
    push_port(0, 64'h1111_0000_0000_0155);
    push_port(0, 64'h1111_0000_0000_0000);
    push_port(1, 64'h2222_0000_0000_0100);
    push_port(2, 64'h3333_0000_0000_0080);
    push_port(3, 64'h4444_0000_0000_0180);
    wait_drain();
    tick(4);

    // back-pressure stalls arbitration
    out_full_fwd = 1;
    s0 = strobe_cnt;
    push_port(1, 64'hABCD_0000_0000_0100);
    tick(10);
    want("bp_no_strobe", 64'(strobe_cnt - s0), 0);
    exp_grant.push_back(4'b0010);
    exp_f(64'hABCD_0000_0000_0080, 1, 1);
    out_full_fwd = 0;
    got = 0;
    for (int i = 0; i < 3 && got == 0; i++) begin
      tick(1);
      if (in_rd != '0) got = 1;
    end
    want("bp_resume", 64'(got), 1);
    wait_drain();
    tick(4);

    // write handshake with a 5-cycle grant delay
    w0 = wrreq_cyc; o0 = rdout_cnt;
    valid_rx = 1; rx_dst_addr = 10'h2AA;
    tick(1);
    valid_rx = 0; rx_dst_addr = 10'h000;
    tick(4);
    write_gnt = 1;
    tick(1);
    write_gnt = 0;
    tick(3);
    want("wr_req_cycles", 64'(wrreq_cyc - w0), 5);
    want("wr_dst_addr", 64'(dst_addr), 64'h2AA);
    want("wr_rd_pulses", 64'(rdout_cnt - o0), 1);
    // reset while a second request is held
    valid_rx = 1; rx_dst_addr = 10'h111;
    tick(1);
    valid_rx = 0;
    tick(2);
    want("wr2_req_held", 64'(write_req), 1);
    do_reset();
    o0 = rdout_cnt;
    tick(1);
    write_gnt = 1;
    tick(1);
    write_gnt = 0;
    tick(2);
    want("post_rst_wr_req", 64'(write_req), 0);
    want("post_rst_no_rd", 64'(rdout_cnt - o0), 0);
    want("post_rst_dst", 64'(dst_addr), 0);
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/router_controller_mp.md
Name: router_controller_mp

Overview:
- Multi-port successor to the single-ring router controller.
- Arbitrates NUM_PORTS input FIFOs round-robin; port 0 is local inject, ports 1..NUM_PORTS-1 are network.
- Applies TTL-based deliver/forward/drop decisions and sequences read/write requests to the memory arbiter with held request/grant handshakes.
- Sits between the input/output port FIFOs, the crossbar data path and the memory arbiter.

Parameters:
DATA_WIDTH, 64, flit width.
ADDR_WIDTH, 10, memory address width.
NUM_PORTS, 4, number of input ports (>=2).
NUMBER_PACKET, 19, max packet sequence number; sequence runs 1..NUMBER_PACKET.
TTL_W, 2, TTL field width.
TTL_INIT, 2, TTL stamped on locally generated headers.
SEQ_W, 5, sequence field width (>= clog2(NUMBER_PACKET+1)).
SRC_W, 2, source-router field width.
SRC_ID, 0, this router's ID.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_req  in  1  read job request from total controller
start_src_addr  in  ADDR_WIDTH  read source address
start_dst_addr  in  ADDR_WIDTH  destination address for outgoing packets
done  out  1  one-cycle pulse when read grant is received
read_req  out  1  arbiter read request
read_gnt  in  1  arbiter read grant
src_addr  out  ADDR_WIDTH  latched read address
ready_encap  in  1  local encapsulator requests a header
hdr_dst_addr  out  ADDR_WIDTH  destination address for the encapsulator
hdr_out  out  TTL_W+SEQ_W+SRC_W  header {TTL, seq, src}
in_empty  in  NUM_PORTS  input FIFO empty flags
in_rd  out  NUM_PORTS  one-hot FIFO read strobes
in_data  in  NUM_PORTS*DATA_WIDTH  FIFO outputs, port p at [p*DATA_WIDTH +: DATA_WIDTH]
out_full_local  in  1  local output FIFO full
out_full_fwd  in  1  forward output FIFO full
out_data  out  DATA_WIDTH  routed flit
out_we_local  out  1  write local output FIFO
out_we_fwd  out  1  write forward output FIFO
drop_cnt  out  16  saturating count of dropped flits
valid_rx  in  1  received packet waiting in local output
rx_dst_addr  in  ADDR_WIDTH  memory address for the received packet
write_req  out  1  arbiter write request
write_gnt  in  1  arbiter write grant
dst_addr  out  ADDR_WIDTH  latched write address
rd_output_local  out  1  one-cycle read strobe to the local output port

Behaviour:
- Reset: all outputs 0, all FSMs in IDLE, rr_ptr=0, seq=0, drop_cnt=0. Reset mid-operation aborts everything, including any held request.
- Read FSM (R_IDLE, R_REQ, R_WAIT):
  - R_IDLE: on start_req, latch src_addr and set read_req=1, go to R_REQ.
  - R_REQ: read_req stays high until read_gnt. On grant: read_req=0 and done=1 for one cycle, go to R_WAIT.
  - R_WAIT: stay until start_req=0, then go to R_IDLE. No retrigger while start_req is held.
  - start_req dropping in R_REQ: clear read_req and return to R_IDLE.
- Header: on each ready_encap cycle, hdr_out <= {TTL_INIT, seq_next, SRC_ID} and hdr_dst_addr <= start_dst_addr.
  - seq_next = (seq==NUMBER_PACKET or seq==0) ? 1 : seq+1; seq <= seq_next.
  - First header after reset carries seq=1.
  - ready_encap held high advances seq every cycle.
- Forward FSM (F_IDLE, F_READ, F_ROUTE):
  - F_IDLE: eligible requires out_full_local=0 and out_full_fwd=0. Pick the first non-empty port at or after rr_ptr (modulo NUM_PORTS), call it sel. If none, stay. Otherwise set rr_ptr <= sel+1 (wrapping) and go to F_READ.
  - F_READ: in_rd[sel]=1 for exactly one cycle, go to F_ROUTE.
  - F_ROUTE: samples in_data[sel], which is valid one cycle after the read strobe. Registered outputs are applied one cycle later, then return to F_IDLE.
- Route decision, with TTL field at flit bits [TTL_W+SEQ_W+SRC_W-1 -: TTL_W]:
  - sel==0: out_data=flit unchanged, out_we_fwd=1.
  - TTL>1: TTL-1 written into out_data, other bits unchanged; out_we_local=1, out_we_fwd=1.
  - TTL==1: TTL=0 written; out_we_local=1 only.
  - TTL==0: no writes; drop_cnt+1, saturating at 0xFFFF.
- Write strobes are one-cycle pulses. out_data holds its value otherwise.
- Throughput: one flit per 3 cycles. Fairness: no non-empty port waits more than NUM_PORTS grants.
- Write FSM (W_IDLE, W_REQ, W_RD):
  - W_IDLE: on valid_rx, latch dst_addr <= rx_dst_addr, write_req=1, go to W_REQ.
  - W_REQ: hold write_req until write_gnt, then write_req=0, rd_output_local=1 for one cycle, go to W_RD.
  - W_RD: go to W_IDLE next cycle. dst_addr holds until the next latch.
- The three FSMs are independent; simultaneous events in each proceed in parallel.

Test Plan:
- rst released, start_req=1, start_src_addr=0x155, read_gnt asserted 3 cycles later -> read_req high for exactly 3 cycles, src_addr=0x155, one done pulse, no second request while start_req stays high.
- ready_encap pulsed 21 times, SRC_ID=0, TTL_INIT=2 -> hdr_out seq sequence 1..19,1,2; TTL field 2; src field 0.
- Port 2 flit with TTL=2 -> in_rd=0b0100 pulse, then out_we_local=out_we_fwd=1, out_data TTL=1, all other bits equal to input; TTL=1 flit -> local only, TTL=0; TTL=0 flit -> no writes, drop_cnt=1.
- All 4 ports non-empty continuously from rr_ptr=0 -> grant order 0,1,2,3,0; port-0 flit forwarded unchanged with out_we_fwd only.
- out_full_fwd=1 with ports non-empty -> in_rd stays 0; deassert -> service resumes within 3 cycles.
- valid_rx=1, rx_dst_addr=0x2AA, write_gnt delayed 5 cycles; then rst pulsed during a second W_REQ -> first transaction: write_req held 5 cycles, dst_addr=0x2AA, single rd_output_local pulse; after reset: write_req=0 immediately, all FSMs idle.
